// File: rtl/btb_assoc_if.sv
// Fetch-lookup, EX-training and flush-control bundle for btb_assoc.
// The slave side belongs to the BTB; the master side drives fetch PCs and training.
interface btb_assoc_if;
    // upd_valid is a valid-only qualifier with no ready. A training beat is taken
    // on any rising edge where upd_valid=1, busy=0 and flush=0; otherwise it is dropped.
    logic [31:0] pc;
    logic        pc_valid;
    logic        hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        flush;
    logic        busy;
    logic        dbg_state;

    modport slave (
        input  pc, pc_valid, upd_valid, upd_pc, upd_target, upd_taken, flush,
        output hit, pred_taken, pred_target, busy, dbg_state
    );

    modport master (
        output pc, pc_valid, upd_valid, upd_pc, upd_target, upd_taken, flush,
        input  hit, pred_taken, pred_target, busy, dbg_state
    );
endinterface

// File: rtl/btb_assoc.sv
// Set-associative BTB with 2-bit direction counters, per-set round-robin victims and a
// one-set-per-cycle flush engine. Define BTB_PERF_EN to add lookup/hit perf counters.
module btb_assoc #(
    parameter int SET_BITS = 6,
    parameter int WAYS     = 2,
    parameter int TAG_BITS = 30 - SET_BITS
) (
    input  logic        clk,
    input  logic        rst,
    btb_assoc_if.slave  bus
`ifdef BTB_PERF_EN
    ,
    output logic [31:0] perf_lookups,
    output logic [31:0] perf_hits
`endif
);
    localparam int SETS = 1 << SET_BITS;
    localparam int WB   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [SET_BITS-1:0] flush_idx_q, flush_idx_d;
    logic                busy_int;

    logic [WAYS-1:0]     valid_q [SETS];
    logic [WB-1:0]       vptr_q  [SETS];
    logic [TAG_BITS-1:0] tag_q   [SETS][WAYS];
    logic [31:0]         tgt_q   [SETS][WAYS];
    logic [1:0]          ctr_q   [SETS][WAYS];

    // ---------------- flush FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            flush_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_idx_q <= flush_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_idx_d = flush_idx_q;
        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    state_d     = FLUSH;
                    flush_idx_d = '0;
                end
            end
            FLUSH: begin
                flush_idx_d = flush_idx_q + 1'b1;
                if (flush_idx_q == SET_BITS'(SETS - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_int      = (state_q == FLUSH);
        bus.busy      = busy_int;
        bus.dbg_state = state_q;
    end

    // ---------------- lookup ----------------
    logic [SET_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0] lk_tag;
    logic                lk_match;
    logic [WB-1:0]       lk_way;

    assign lk_idx = bus.pc[SET_BITS+1:2];
    assign lk_tag = bus.pc[31:SET_BITS+2];

    // Descending scan so the lowest matching way is the one left standing.
    always_comb begin
        lk_match = 1'b0;
        lk_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && tag_q[lk_idx][w] == lk_tag) begin
                lk_match = 1'b1;
                lk_way   = WB'(w);
            end
        end
    end

    always_comb begin
        bus.hit         = lk_match && !busy_int;
        bus.pred_taken  = bus.hit && ctr_q[lk_idx][lk_way][1];
        bus.pred_target = bus.pred_taken ? tgt_q[lk_idx][lk_way] : bus.pc + 32'd4;
    end

    // ---------------- training ----------------
    logic [SET_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                u_hit, u_inv;
    logic [WB-1:0]       u_hway, u_iway, alloc_way, wr_way, vptr_adv;
    logic                do_upd, wr_hit, wr_alloc, wr_tgt;
    logic [1:0]          ctr_cur, ctr_next;

    assign upd_idx = bus.upd_pc[SET_BITS+1:2];
    assign upd_tag = bus.upd_pc[31:SET_BITS+2];

    always_comb begin
        u_hit  = 1'b0;
        u_hway = '0;
        u_inv  = 1'b0;
        u_iway = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[upd_idx][w] && tag_q[upd_idx][w] == upd_tag) begin
                u_hit  = 1'b1;
                u_hway = WB'(w);
            end
            if (!valid_q[upd_idx][w]) begin
                u_inv  = 1'b1;
                u_iway = WB'(w);
            end
        end
    end

    always_comb begin
        do_upd    = bus.upd_valid && (state_q == IDLE) && !bus.flush;
        wr_hit    = do_upd && u_hit;
        wr_alloc  = do_upd && !u_hit && bus.upd_taken;
        alloc_way = u_inv ? u_iway : vptr_q[upd_idx];
        wr_way    = u_hit ? u_hway : alloc_way;
        wr_tgt    = wr_alloc || (wr_hit && bus.upd_taken);
        vptr_adv  = (vptr_q[upd_idx] == WB'(WAYS - 1)) ? '0 : vptr_q[upd_idx] + 1'b1;
        ctr_cur   = ctr_q[upd_idx][u_hway];
        if (!u_hit)             ctr_next = 2'd2;
        else if (bus.upd_taken) ctr_next = (ctr_cur == 2'd3) ? 2'd3 : ctr_cur + 2'd1;
        else                    ctr_next = (ctr_cur == 2'd0) ? 2'd0 : ctr_cur - 2'd1;
    end

    // Payload arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (wr_hit || wr_alloc) begin
            ctr_q[upd_idx][wr_way] <= ctr_next;
            if (wr_tgt)   tgt_q[upd_idx][wr_way] <= bus.upd_target;
            if (wr_alloc) tag_q[upd_idx][wr_way] <= upd_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
        end else if (state_q == FLUSH) begin
            valid_q[flush_idx_q] <= '0;
            vptr_q[flush_idx_q]  <= '0;
        end else if (wr_alloc) begin
            valid_q[upd_idx][alloc_way] <= 1'b1;
            // Only evicting a live entry moves the round-robin pointer.
            if (!u_inv) vptr_q[upd_idx] <= vptr_adv;
        end
    end

    // ---------------- optional perf counters ----------------
`ifdef BTB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_lookups <= '0;
            perf_hits    <= '0;
        end else if (bus.pc_valid && !busy_int) begin
            if (perf_lookups != 32'hFFFF_FFFF) perf_lookups <= perf_lookups + 32'd1;
            if (bus.hit && perf_hits != 32'hFFFF_FFFF) perf_hits <= perf_hits + 32'd1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^bus.upd_pc[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{bus.upd_pc[1:0], bus.pc_valid};
`endif
endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc (SET_BITS=6, WAYS=2); perf checks compile in with BTB_PERF_EN.
module tb_btb_assoc;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  btb_assoc_if bif();

`ifdef BTB_PERF_EN
  logic [31:0] perf_lookups;
  logic [31:0] perf_hits;
`endif

  btb_assoc #(.SET_BITS(6), .WAYS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
`ifdef BTB_PERF_EN
    ,
    .perf_lookups (perf_lookups),
    .perf_hits    (perf_hits)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
    bif.upd_valid  = 1'b1;
    bif.upd_pc     = p;
    bif.upd_target = t;
    bif.upd_taken  = tk;
    tick();
    bif.upd_valid  = 1'b0;
  endtask

  task automatic look(input logic [31:0] p);
    bif.pc = p;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    look(32'h100);
    tick();
    n_tests++; if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %0b want 0", bif.hit); end
    n_tests++; if (bif.pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pt got %0b want 0", bif.pred_taken); end
    n_tests++; if (bif.pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_tgt got %h want 00000104", bif.pred_target); end
    n_tests++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bif.busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_counter();
    upd(32'h100, 32'h200, 1'b1);
    look(32'h100);
    n_tests++; if (bif.hit !== 1'b1) begin n_fail++; $display("FAIL ctr_alloc_hit got %0b want 1", bif.hit); end
    n_tests++; if (bif.pred_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_alloc_pt got %0b want 1", bif.pred_taken); end
    n_tests++; if (bif.pred_target !== 32'h200) begin n_fail++; $display("FAIL ctr_alloc_tgt got %h want 00000200", bif.pred_target); end
    // 2 -> 3 -> 3 (saturate), then not-taken with a different target must not overwrite it
    upd(32'h100, 32'h300, 1'b1);
    upd(32'h100, 32'h300, 1'b1);
    upd(32'h100, 32'h777, 1'b0);
    look(32'h100);
    n_tests++; if (bif.pred_taken !== 1'b1) begin n_fail++; $display("FAIL ctr_sat3_pt got %0b want 1", bif.pred_taken); end
    n_tests++; if (bif.pred_target !== 32'h300) begin n_fail++; $display("FAIL ctr_nt_keep_tgt got %h want 00000300", bif.pred_target); end
    upd(32'h100, 32'h300, 1'b0);
    upd(32'h100, 32'h300, 1'b0);
    upd(32'h100, 32'h300, 1'b0);
    look(32'h100);
    n_tests++; if (bif.hit !== 1'b1) begin n_fail++; $display("FAIL ctr_zero_hit got %0b want 1", bif.hit); end
    n_tests++; if (bif.pred_taken !== 1'b0) begin n_fail++; $display("FAIL ctr_zero_pt got %0b want 0", bif.pred_taken); end
    n_tests++; if (bif.pred_target !== 32'h104) begin n_fail++; $display("FAIL ctr_zero_tgt got %h want 00000104", bif.pred_target); end
    // counter 0 -> 1 is still not-taken, 1 -> 2 predicts taken again
    upd(32'h100, 32'h240, 1'b1);
    look(32'h100);
    n_tests++; if (bif.pred_taken !== 1'b0) begin n_fail++; $display("FAIL ctr_one_pt got %0b want 0", bif.pred_taken); end
    upd(32'h100, 32'h250, 1'b1);
    look(32'h100);
    n_tests++; if (bif.pred_target !== 32'h250) begin n_fail++; $display("FAIL ctr_two_tgt got %h want 00000250", bif.pred_target); end
  endtask

  task automatic test_replacement();
    // set 0 way0 already holds 0x100; 0x1100 takes the invalid way1 without moving the pointer
    upd(32'h1100, 32'h1200, 1'b1);
    upd(32'h2100, 32'h2200, 1'b1);
    look(32'h100);
    n_tests++; if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL repl_evict0 got %0b want 0", bif.hit); end
    look(32'h1100);
    n_tests++; if (bif.pred_target !== 32'h1200) begin n_fail++; $display("FAIL repl_keep1100 got %h want 00001200", bif.pred_target); end
    look(32'h2100);
    n_tests++; if (bif.pred_target !== 32'h2200) begin n_fail++; $display("FAIL repl_new2100 got %h want 00002200", bif.pred_target); end
    upd(32'h3100, 32'h3200, 1'b1);
    look(32'h1100);
    n_tests++; if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL repl_evict1100 got %0b want 0", bif.hit); end
    look(32'h2100);
    n_tests++; if (bif.hit !== 1'b1) begin n_fail++; $display("FAIL repl_keep2100 got %0b want 1", bif.hit); end
    look(32'h3100);
    n_tests++; if (bif.pred_target !== 32'h3200) begin n_fail++; $display("FAIL repl_new3100 got %h want 00003200", bif.pred_target); end
  endtask

  task automatic test_not_taken_miss();
    upd(32'h400, 32'h480, 1'b0);
    look(32'h400);
    n_tests++; if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL ntmiss_hit got %0b want 0", bif.hit); end
    look(32'h2100);
    n_tests++; if (bif.hit !== 1'b1) begin n_fail++; $display("FAIL ntmiss_noevict got %0b want 1", bif.hit); end
    look(32'hFFFF_FFFC);
    n_tests++; if (bif.pred_target !== 32'h0) begin n_fail++; $display("FAIL wrap_tgt got %h want 00000000", bif.pred_target); end
  endtask

  task automatic test_same_cycle();
    // lookup sees pre-update contents of the set being trained
    bif.pc         = 32'h2100;
    bif.upd_valid  = 1'b1;
    bif.upd_pc     = 32'h2100;
    bif.upd_target = 32'h2900;
    bif.upd_taken  = 1'b1;
    #1;
    n_tests++; if (bif.pred_target !== 32'h2200) begin n_fail++; $display("FAIL bypass_old got %h want 00002200", bif.pred_target); end
    tick();
    bif.upd_valid = 1'b0;
    #1;
    n_tests++; if (bif.pred_target !== 32'h2900) begin n_fail++; $display("FAIL bypass_new got %h want 00002900", bif.pred_target); end
  endtask

  task automatic test_flush();
    int cnt;
    upd(32'h104, 32'h600, 1'b1);
    bif.pc         = 32'h2100;
    bif.flush      = 1'b1;
    bif.upd_valid  = 1'b1;
    bif.upd_pc     = 32'h800;
    bif.upd_target = 32'h880;
    bif.upd_taken  = 1'b1;
    tick();
    bif.flush  = 1'b0;
    bif.upd_pc = 32'h900;
    cnt = 0;
    while (bif.busy === 1'b1 && cnt < 200) begin
      if (bif.hit !== 1'b0 || bif.pred_target !== 32'h2104) begin
        n_fail++;
        $display("FAIL flush_quiet cyc %0d got hit=%0b tgt=%h want hit=0 tgt=00002104", cnt, bif.hit, bif.pred_target);
      end
      bif.flush = (cnt == 10);
      cnt++;
      tick();
    end
    bif.upd_valid = 1'b0;
    bif.flush     = 1'b0;
    n_tests++; if (cnt !== 64) begin n_fail++; $display("FAIL flush_len got %0d want 64", cnt); end
    n_tests++;
    look(32'h2100); if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL flush_gone2100 got %0b want 0", bif.hit); end
    look(32'h104);  if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL flush_gone104 got %0b want 0", bif.hit); end
    look(32'h3100); if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL flush_gone3100 got %0b want 0", bif.hit); end
    n_tests++;
    look(32'h800); if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL flush_drop800 got %0b want 0", bif.hit); end
    look(32'h900); if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL flush_drop900 got %0b want 0", bif.hit); end
    // victim pointers also cleared: two fresh allocs fill way0 then way1, third evicts way0
    upd(32'h1100, 32'h11, 1'b1);
    upd(32'h2100, 32'h22, 1'b1);
    upd(32'h3100, 32'h33, 1'b1);
    look(32'h1100);
    n_tests++; if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL flush_vptr got %0b want 0", bif.hit); end
  endtask

  task automatic test_reset_mid_flush();
    bif.flush = 1'b1;
    tick();
    bif.flush = 1'b0;
    n_tests++; if (bif.busy !== 1'b1) begin n_fail++; $display("FAIL rstflush_busy1 got %0b want 1", bif.busy); end
    repeat (5) tick();
    rst = 1'b1;
    #1;
    n_tests++; if (bif.busy !== 1'b0) begin n_fail++; $display("FAIL rstflush_busy0 got %0b want 0", bif.busy); end
    tick();
    rst = 1'b0;
    tick();
    look(32'h2100);
    n_tests++; if (bif.hit !== 1'b0) begin n_fail++; $display("FAIL rstflush_inval got %0b want 0", bif.hit); end
    upd(32'h140, 32'h1234, 1'b1);
    look(32'h140);
    n_tests++; if (bif.pred_target !== 32'h1234) begin n_fail++; $display("FAIL rstflush_train got %h want 00001234", bif.pred_target); end
  endtask

`ifdef BTB_PERF_EN
  task automatic test_perf();
    do_reset();
    upd(32'h100, 32'h200, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bif.pc       = (i < 4) ? 32'h100 : 32'h500;
      bif.pc_valid = 1'b1;
      tick();
    end
    bif.pc_valid = 1'b0;
    tick();
    n_tests++; if (perf_lookups !== 32'd10) begin n_fail++; $display("FAIL perf_lookups got %0d want 10", perf_lookups); end
    n_tests++; if (perf_hits !== 32'd4) begin n_fail++; $display("FAIL perf_hits got %0d want 4", perf_hits); end
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bif.pc         = 32'h0;
    bif.pc_valid   = 1'b0;
    bif.upd_valid  = 1'b0;
    bif.upd_pc     = 32'h0;
    bif.upd_target = 32'h0;
    bif.upd_taken  = 1'b0;
    bif.flush      = 1'b0;
    test_reset();
    test_counter();
    test_replacement();
    test_not_taken_miss();
    test_same_cycle();
    test_flush();
    test_reset_mid_flush();
`ifdef BTB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
